piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 WIDTH, default 8, serial word length in bits; legal range WIDTH >= 2.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn_i  input  1  asynchronous, active-low reset.
REQ-004 en_i  input  1  sink advance; 1 = current serial bit consumed this cycle.
REQ-005 dir_i  input  1  bit order, sampled at load; 0 = MSB first, 1 = LSB first.
REQ-006 valid_i  input  1  parallel word valid.
REQ-007 data_i  input  WIDTH  parallel word to serialize.
REQ-008 ready_o  output  1  block accepts a parallel word this cycle.
REQ-009 data_o  output  1  current serial bit.
REQ-010 valid_o  output  1  data_o holds a valid bit.
REQ-011 last_o  output  1  data_o is the final bit of the current word.
REQ-012 busy_o  output  1  a word is being shifted out.

Function
REQ-013 The block SHALL have two states: IDLE and SHIFT.
REQ-014 Load: on a rising edge with valid_i=1 and ready_o=1, the block SHALL capture data_i into the shift register and dir_i into a direction flag, clear the bit counter, and enter SHIFT.
REQ-015 ready_o SHALL be 1 in IDLE, and 1 in SHIFT only when last_o=1 and en_i=1; it SHALL be 0 otherwise (combinational, zero-bubble reload).
REQ-016 In SHIFT, valid_o and busy_o SHALL be 1 and data_o SHALL be the shift register MSB (flag=0) or LSB (flag=1).
REQ-017 In IDLE, valid_o, busy_o, last_o and data_o SHALL be 0.
REQ-018 In SHIFT with en_i=1 and last_o=0, the register SHALL shift by one position (left for flag=0, right for flag=1, with 0 filled in) and the counter SHALL increment by 1.
REQ-019 In SHIFT with en_i=0, the register, counter, flag and all outputs SHALL hold.
REQ-020 The counter SHALL be $clog2(WIDTH) bits wide; last_o SHALL be 1 iff the state is SHIFT and counter == WIDTH-1.
REQ-021 In SHIFT with last_o=1 and en_i=1: if valid_i=1, the block SHALL load the new word per REQ-014 and stay in SHIFT; otherwise it SHALL return to IDLE.
REQ-022 Latency: a word accepted at edge k SHALL present its first bit from edge k until the first edge with en_i=1; each word needs exactly WIDTH cycles with en_i=1.
REQ-023 valid_i while ready_o=0 SHALL be ignored, with no state change.
REQ-024 A change of dir_i during SHIFT SHALL NOT affect the word in progress.

Reset
REQ-025 rstn_i=0 SHALL immediately, without a clock edge, force IDLE, clear the shift register, counter and flag, and drive valid_o=0, data_o=0, last_o=0, busy_o=0 and ready_o=1.
REQ-026 Reset asserted mid-word SHALL discard the remaining bits; after release, the next accepted word SHALL start from bit 0.
REQ-027 The first load SHALL be possible on the first rising edge after rstn_i deasserts.

Verification
REQ-028 WIDTH=8, load 0x1E with dir_i=0, en_i=1 -> data_o = 0,0,0,1,1,1,1,0 on 8 consecutive cycles; last_o=1 on the 8th only; then IDLE.
REQ-029 Load 0x1E with dir_i=1, en_i=1 -> data_o = 0,1,1,1,1,0,0,0; toggling dir_i mid-word changes nothing.
REQ-030 Load 0xA5, en_i=0 for 3 cycles after bit 2 -> data_o and valid_o hold for those cycles; word completes after 11 cycles in SHIFT.
REQ-031 valid_i held high with words 0x1E then 0xC3, en_i=1 -> 16 contiguous cycles with valid_o=1, bits 0,0,0,1,1,1,1,0,1,1,0,0,0,0,1,1; ready_o=1 only on the two last_o cycles.
REQ-032 rstn_i pulsed low between clock edges after 4 bits -> valid_o=0 and ready_o=1 before the next edge; after release, a load of 0x80 (dir_i=0) emits a 1 first.
REQ-033 valid_i=1 with word 0xFF during bit 3 of a word in flight -> ignored, the word in flight is unaffected, and no extra word is emitted.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with zero-bubble reload
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             load;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    busy_o  = (state_q == SHIFT);
    valid_o = (state_q == SHIFT);
    last_o  = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    data_o  = 1'b0;
    if (state_q == SHIFT) begin
      data_o = flag_q ? sreg_q[0] : sreg_q[WIDTH-1];
    end
    // Ready on the final consumed bit lets the next word follow with no gap.
    ready_o = (state_q == IDLE) || (last_o && en_i);
    load    = valid_i && ready_o;

    if (load) begin
      state_d = SHIFT;
      sreg_d  = data_i;
      flag_d  = dir_i;
      cnt_d   = '0;
    end else if (state_q == SHIFT && en_i) begin
      if (last_o) begin
        state_d = IDLE;
      end else begin
        sreg_d = flag_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized and directed bench against a bit-queue model
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             en_i = 1'b0;
  logic             dir_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             ready_o, data_o, valid_o, last_o, busy_o;

  int total = 0;
  int bad = 0;

  logic s_data, s_valid, s_last, s_ready, s_busy;
  logic [15:0] bits, lasts, readys;
  int busy_cnt;

  // Model: the bits still owed to the sink, in emission order.
  bit mq[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (en_i),
    .dir_i   (dir_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mq.delete();
    end else begin
      automatic bit rdy = (mq.size() == 0) || (mq.size() == 1 && en_i);
      if (mq.size() != 0 && en_i) void'(mq.pop_front());
      if (valid_i && rdy) begin
        for (int i = 0; i < WIDTH; i++)
          mq.push_back(dir_i ? data_i[i] : data_i[WIDTH-1-i]);
      end
    end
  end

  always @(negedge clk_i) begin
    automatic bit nz = (mq.size() != 0);
    chk("valid_o", 16'(valid_o), 16'(nz));
    chk("busy_o", 16'(busy_o), 16'(nz));
    chk("data_o", 16'(data_o), 16'(nz ? mq[0] : 1'b0));
    chk("last_o", 16'(last_o), 16'(mq.size() == 1));
    chk("ready_o", 16'(ready_o), 16'((mq.size() == 0) || (mq.size() == 1 && en_i)));
  end

  task automatic cyc(input logic en, input logic v, input logic d, input logic [WIDTH-1:0] w);
    en_i = en; valid_i = v; dir_i = d; data_i = w;
    @(negedge clk_i);
    s_data = data_o; s_valid = valid_o; s_last = last_o; s_ready = ready_o; s_busy = busy_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [10:0] enpat;
    @(posedge clk_i); #1;
    chk("rst_ready", 16'(ready_o), 16'd1);
    chk("rst_idle", {12'd0, valid_o, busy_o, last_o, data_o}, 16'd0);
    cyc(0, 0, 0, 0);
    rstn_i = 1'b1;

    // MSB first 0x1E
    cyc(1, 1, 0, 8'h1E);
    bits = 0; lasts = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0);
      bits = {bits[14:0], s_data}; lasts = {lasts[14:0], s_last};
    end
    chk("msb_bits", bits[7:0], 16'h1E);
    chk("msb_last", lasts[7:0], 16'h01);
    cyc(1, 0, 0, 0);
    chk("msb_idle", 16'(s_valid), 16'd0);

    // LSB first 0x1E with dir toggling mid-word
    cyc(1, 1, 1, 8'h1E);
    bits = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, i[0], 0);
      bits = {bits[14:0], s_data};
    end
    chk("lsb_bits", bits[7:0], 16'h78);

    // 0xA5 with a 3-cycle stall after two bits
    enpat = 11'b11000111111;
    cyc(1, 1, 0, 8'hA5);
    bits = 0; busy_cnt = 0;
    for (int i = 10; i >= 0; i--) begin
      cyc(enpat[i], 0, 0, 0);
      if (s_busy) busy_cnt++;
      if (enpat[i]) bits = {bits[14:0], s_data};
    end
    chk("stall_bits", bits[7:0], 16'hA5);
    chk("stall_busy", 16'(busy_cnt), 16'd11);
    cyc(1, 0, 0, 0);
    chk("stall_done", 16'(s_busy), 16'd0);

    // back-to-back 0x1E then 0xC3
    cyc(1, 1, 0, 8'h1E);
    bits = 0; readys = 0; busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, i < 8, 0, 8'hC3);
      bits = {bits[14:0], s_data}; readys = {readys[14:0], s_ready};
      if (s_valid) busy_cnt++;
    end
    chk("b2b_bits", bits, 16'h1EC3);
    chk("b2b_ready", readys, 16'h0101);
    chk("b2b_valid", 16'(busy_cnt), 16'd16);

    // asynchronous reset mid-word
    cyc(1, 1, 0, 8'h1E);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    rstn_i = 1'b0; #1;
    chk("arst_valid", 16'(valid_o), 16'd0);
    chk("arst_ready", 16'(ready_o), 16'd1);
    chk("arst_busy", 16'(busy_o), 16'd0);
    #1 rstn_i = 1'b1;
    cyc(1, 1, 0, 8'h80);
    cyc(1, 0, 0, 0);
    chk("arst_first", {14'd0, s_valid, s_data}, 16'd3);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);

    // word offered while busy is ignored
    cyc(1, 1, 0, 8'h3C);
    bits = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 3, 0, 8'hFF);
      bits = {bits[14:0], s_data};
    end
    chk("ign_bits", bits[7:0], 16'h3C);
    cyc(1, 0, 0, 0);
    chk("ign_idle", 16'(s_valid), 16'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
          WIDTH'($urandom));
      if ($urandom_range(0, 400) == 0) begin
        rstn_i = 1'b0; #2 rstn_i = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
